audio_iir1_filter: RTL and testbench
====================================

// Module: audio_iir1_filter
// PURPOSE
//  Parametrised first-order IIR audio filter; successor to the fixed stereo high-pass stage.
//  Runtime-selectable mode (bypass / high-pass / low-pass) and runtime coefficient alpha.
//  N interleaved channels share one time-multiplexed multiplier, processed once per sample frame.
//  Sits between the codec input deserialiser and the DAC serialiser, clocked by AUD_BCLK.
// PARAMETERS
//  DATA_W    32  signed two's-complement sample width per channel
//  COEF_W    16  alpha width; unsigned Q1.(COEF_W-1): alpha = code/2^(COEF_W-1), range 0..<2.0
//  CHANNELS  2   channel count (>=1); channel k occupies bits [k*DATA_W +: DATA_W]
// PORTS
//  AUD_BCLK     in   1                  clock
//  reset        in   1                  asynchronous, active-low reset
//  AUD_DACLRCK  in   1                  frame strobe; rising edge starts one frame of processing
//  mode         in   2                  00 bypass, 01 high-pass, 10 low-pass, 11 = bypass
//  alpha        in   COEF_W             filter coefficient, Q1.(COEF_W-1)
//  audio_in     in   CHANNELS*DATA_W    packed input samples
//  audio_out    out  CHANNELS*DATA_W    packed filtered samples, registered
//  out_valid    out  1                  1-cycle pulse when audio_out updates
//  busy         out  1                  high from accepted edge until out_valid cycle inclusive
//  overrun      out  1                  1-cycle pulse when an edge arrives while busy
//  sat          out  1                  sticky; set when any result saturates, cleared only by reset
// BEHAVIOUR
//  Reset (async, reset==0):
//   - audio_out, out_valid, busy, overrun, sat = 0.
//   - x_prev/y_prev history for all channels = 0; latched mode = 00.
//   - FSM -> IDLE; edge-detect register = 0.
//   - A reset mid-frame aborts the frame; no partial output.
//  Edge detect: dlr_q <= AUD_DACLRCK each cycle; edge = AUD_DACLRCK & ~dlr_q.
//  FSM: IDLE -> LOAD -> {SUM -> MUL -> WRITE} x CHANNELS -> DONE -> IDLE.
//   - IDLE: an edge moves to LOAD next cycle, busy=1.
//   - LOAD: snapshot audio_in, mode, alpha. If mode differs from the previously latched mode,
//     clear all history to 0 before computing. Channel index ch=0.
//   - SUM: s = HP: y_prev+x-x_prev; LP: x-y_prev; bypass: x. Width DATA_W+2, signed.
//   - MUL: p = (s * alpha) >>> (COEF_W-1), arithmetic shift (floor). Alpha is zero-extended.
//   - WRITE: r = HP: p; LP: y_prev+p; bypass: x.
//     Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set sat on clip.
//     Store into a per-channel result register and y_prev[ch]; x_prev[ch] <= x.
//     ch++; go to SUM if ch<CHANNELS, else DONE.
//   - DONE: all channels load into audio_out simultaneously; out_valid=1 for this cycle; busy drops next cycle.
//  Latency: edge cycle E -> out_valid at E+2+3*CHANNELS (E+8 for CHANNELS=2).
//  Edge while busy (including DONE): frame ignored, overrun pulses 1 cycle, state unaffected.
//  Edge coincident with reset deassertion: ignored (dlr_q reset to 0 still requires a registered
//   low first). audio_out holds between frames.
//  mode/alpha changes outside LOAD have no effect until the next frame.
// TESTING (DATA_W=32, COEF_W=16, CHANNELS=2)
//  1. Assert reset mid-frame (cycle E+4) -> all outputs 0 next edge; busy 0; a later frame works normally.
//  2. Bypass, in ch0=0x00001234, ch1=0xFFFFFF00 -> audio_out equals input at E+8, out_valid 1 cycle.
//  3. HP alpha=0x4000 (0.5), x=1000 held on both ch for 3 frames -> y = 500, 250, 125.
//  4. LP alpha=0x2000 (0.25), x=-4000 for 2 frames -> y = -1000, -1750.
//     Then switch to HP -> history cleared, y = floor(0.5*(-4000)) = -2000 with alpha=0x4000.
//  5. HP alpha=0x8001 from reset, x=0x7FFFFFFF -> y=0x7FFFFFFF (saturated), sat=1 and stays 1.
//  6. Second DACLRCK edge 3 cycles after first -> overrun pulse 1 cycle, only one out_valid, values from frame 1.

Source files
------------

// File: rtl/audio_iir1_filter.sv
// ---------------------------------------------------------------------------
// audio_iir1_filter
//   First-order IIR audio filter with runtime mode and coefficient. The filter
//   processes N interleaved channels once per sample frame and shares one
//   multiplier across them. It sits between the codec input deserialiser and
//   the DAC serialiser.
//
//   Per channel, with x = new sample and p = floor(s * alpha):
//     high-pass: s = y_prev + x - x_prev,  y = p
//     low-pass : s = x - y_prev,           y = y_prev + p
//     bypass   : y = x
//   Results are clamped to the DATA_W signed range.
//
// Ports
//   AUD_BCLK     in   clock
//   reset        in   asynchronous, active-low reset
//   AUD_DACLRCK  in   frame strobe; a rising edge starts one frame
//   mode         in   00 bypass, 01 high-pass, 10 low-pass, 11 bypass
//   alpha        in   coefficient, unsigned Q1.(COEF_W-1)
//   audio_in     in   packed samples, channel k at [k*DATA_W +: DATA_W]
//   audio_out    out  packed filtered samples, held between frames
//   out_valid    out  one-cycle pulse when audio_out updates
//   busy         out  high while a frame is in flight
//   overrun      out  one-cycle pulse when a frame strobe arrives while busy
//   sat          out  sticky clip flag, cleared only by reset
// ---------------------------------------------------------------------------
module audio_iir1_filter #(
  parameter int DATA_W   = 32,
  parameter int COEF_W   = 16,
  parameter int CHANNELS = 2
) (
  input  logic                         AUD_BCLK,
  input  logic                         reset,
  input  logic                         AUD_DACLRCK,
  input  logic [1:0]                   mode,
  input  logic [COEF_W-1:0]            alpha,
  input  logic [CHANNELS*DATA_W-1:0]   audio_in,
  output logic [CHANNELS*DATA_W-1:0]   audio_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         sat
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW   = DATA_W + 2;           // pre-multiply sum
  localparam int PW   = SW + COEF_W + 1;      // product with zero-extended alpha
  localparam int RW   = PW + 1;               // result before clamping

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  localparam logic signed [DATA_W-1:0] MAX_DATA = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_DATA = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [RW-1:0]     MAX_R    = RW'(MAX_DATA);
  localparam logic signed [RW-1:0]     MIN_R    = RW'(MIN_DATA);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SUM   = 3'd2;
  localparam logic [2:0] ST_MUL   = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]                  state_reg;
  logic [CH_W-1:0]             ch_reg;
  logic                        dlr_q;
  logic                        low_seen_reg;
  logic [1:0]                  mode_lat_reg;
  logic [COEF_W-1:0]           alpha_lat_reg;
  logic signed [DATA_W-1:0]    x_snap_reg [CHANNELS];
  logic signed [DATA_W-1:0]    x_prev_reg [CHANNELS];
  logic signed [DATA_W-1:0]    y_prev_reg [CHANNELS];
  logic signed [DATA_W-1:0]    res_reg    [CHANNELS];
  logic signed [SW-1:0]        s_reg;
  logic signed [PW-1:0]        p_reg;
  logic [CHANNELS*DATA_W-1:0]  audio_out_reg;
  logic                        overrun_reg;
  logic                        sat_reg;

  logic                        edge_det;
  logic                        busy_c;
  logic signed [DATA_W-1:0]    audio_in_ch [CHANNELS];
  logic signed [DATA_W-1:0]    x_cur;
  logic signed [DATA_W-1:0]    xp_cur;
  logic signed [DATA_W-1:0]    yp_cur;
  logic signed [SW-1:0]        sum_c;
  logic signed [PW-1:0]        prod_c;
  logic signed [PW-1:0]        scaled_c;
  logic signed [RW-1:0]        r_c;
  logic                        clip_hi;
  logic                        clip_lo;
  logic signed [DATA_W-1:0]    r_sat;
  logic [CHANNELS*DATA_W-1:0]  out_next;

  // A strobe already high when reset releases must first be seen low before
  // it can start a frame, so low_seen_reg gates the edge detector.
  assign edge_det = AUD_DACLRCK & ~dlr_q & low_seen_reg;
  assign busy_c   = (state_reg != ST_IDLE);

  assign x_cur  = x_snap_reg[ch_reg];
  assign xp_cur = x_prev_reg[ch_reg];
  assign yp_cur = y_prev_reg[ch_reg];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign audio_in_ch[gi] = audio_in[gi*DATA_W +: DATA_W];
      // The last channel's result is still combinational when the frame
      // completes. It is merged here so that all channels update together.
      assign out_next[gi*DATA_W +: DATA_W] =
        (ch_reg == CH_W'(gi)) ? r_sat : res_reg[gi];
    end
  endgenerate

  always_comb begin
    sum_c = SW'(x_cur);
    case (mode_lat_reg)
      2'b01:   sum_c = SW'(yp_cur) + SW'(x_cur) - SW'(xp_cur);
      2'b10:   sum_c = SW'(x_cur) - SW'(yp_cur);
      default: sum_c = SW'(x_cur);
    endcase
  end

  // Alpha is unsigned, so it is zero-extended before the signed multiply.
  // The arithmetic shift rounds toward negative infinity.
  assign prod_c   = PW'(s_reg) * PW'($signed({1'b0, alpha_lat_reg}));
  assign scaled_c = prod_c >>> (COEF_W - 1);

  always_comb begin
    r_c = RW'(x_cur);
    case (mode_lat_reg)
      2'b01:   r_c = RW'(p_reg);
      2'b10:   r_c = RW'(yp_cur) + RW'(p_reg);
      default: r_c = RW'(x_cur);
    endcase
  end

  assign clip_hi = (r_c > MAX_R);
  assign clip_lo = (r_c < MIN_R);
  assign r_sat   = clip_hi ? MAX_DATA : (clip_lo ? MIN_DATA : r_c[DATA_W-1:0]);

  always_ff @(posedge AUD_BCLK or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      ch_reg        <= '0;
      dlr_q         <= 1'b0;
      low_seen_reg  <= 1'b0;
      mode_lat_reg  <= 2'b00;
      alpha_lat_reg <= '0;
      s_reg         <= '0;
      p_reg         <= '0;
      audio_out_reg <= '0;
      overrun_reg   <= 1'b0;
      sat_reg       <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        x_snap_reg[k] <= '0;
        x_prev_reg[k] <= '0;
        y_prev_reg[k] <= '0;
        res_reg[k]    <= '0;
      end
    end else begin
      dlr_q        <= AUD_DACLRCK;
      low_seen_reg <= low_seen_reg | ~AUD_DACLRCK;
      // A strobe during a frame is dropped. Only this flag records it.
      overrun_reg  <= edge_det & busy_c;

      case (state_reg)
        ST_IDLE: begin
          if (edge_det) state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          mode_lat_reg  <= mode;
          alpha_lat_reg <= alpha;
          for (int k = 0; k < CHANNELS; k++) begin
            x_snap_reg[k] <= audio_in_ch[k];
          end
          // History from another mode would produce a step transient.
          if (mode != mode_lat_reg) begin
            for (int k = 0; k < CHANNELS; k++) begin
              x_prev_reg[k] <= '0;
              y_prev_reg[k] <= '0;
            end
          end
          ch_reg    <= '0;
          state_reg <= ST_SUM;
        end
        ST_SUM: begin
          s_reg     <= sum_c;
          state_reg <= ST_MUL;
        end
        ST_MUL: begin
          p_reg     <= scaled_c;
          state_reg <= ST_WRITE;
        end
        ST_WRITE: begin
          res_reg[ch_reg]    <= r_sat;
          y_prev_reg[ch_reg] <= r_sat;
          x_prev_reg[ch_reg] <= x_cur;
          if (clip_hi || clip_lo) sat_reg <= 1'b1;
          if (ch_reg == LAST_CH) begin
            audio_out_reg <= out_next;
            state_reg     <= ST_DONE;
          end else begin
            ch_reg    <= ch_reg + CH_W'(1);
            state_reg <= ST_SUM;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign audio_out = audio_out_reg;
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = busy_c;
  assign overrun   = overrun_reg;
  assign sat       = sat_reg;

endmodule

// File: tb/tb_audio_iir1_filter.sv
// ---------------------------------------------------------------------------
// tb_audio_iir1_filter
//   Scoreboard bench for audio_iir1_filter (DATA_W=32, COEF_W=16, CHANNELS=2).
//   The stimulus pushes expected frames computed by an arithmetic reference
//   model. A monitor pops and compares them on each out_valid.
// ---------------------------------------------------------------------------
module tb_audio_iir1_filter;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int NCH = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 dlrck;
  logic [1:0]           mode;
  logic [CW-1:0]        alpha;
  logic [NCH*DW-1:0]    audio_in;
  logic [NCH*DW-1:0]    audio_out;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;
  logic                 sat;

  always #5 clk = ~clk;

  audio_iir1_filter #(.DATA_W(DW), .COEF_W(CW), .CHANNELS(NCH)) dut (
    .AUD_BCLK    (clk),
    .reset       (rst_n),
    .AUD_DACLRCK (dlrck),
    .mode        (mode),
    .alpha       (alpha),
    .audio_in    (audio_in),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .sat         (sat)
  );

  typedef struct {
    logic [NCH*DW-1:0] data;
    int                edge_cyc;
    bit                sat;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     ov_cnt = 0;
  int     busy_cnt = 0;

  // Reference model state
  longint     m_xp[NCH];
  longint     m_yp[NCH];
  logic [1:0] m_mode;
  bit         m_sat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_xp[k] = 0;
      m_yp[k] = 0;
    end
    m_mode = 2'b00;
    m_sat  = 1'b0;
  endtask

  task automatic model_frame(input logic [1:0] m, input logic [CW-1:0] a,
                             input logic [NCH*DW-1:0] xin, output logic [NCH*DW-1:0] yout);
    longint x, r, av;
    logic signed [DW-1:0] xs;
    av = a;
    if (m != m_mode) begin
      for (int k = 0; k < NCH; k++) begin
        m_xp[k] = 0;
        m_yp[k] = 0;
      end
    end
    m_mode = m;
    yout = '0;
    for (int k = 0; k < NCH; k++) begin
      xs = xin[k*DW +: DW];
      x  = xs;
      case (m)
        2'b01:   r = floor_div((m_yp[k] + x - m_xp[k]) * av, 32768);
        2'b10:   r = m_yp[k] + floor_div((x - m_yp[k]) * av, 32768);
        default: r = x;
      endcase
      if (r > 64'sd2147483647) begin
        r = 64'sd2147483647;
        m_sat = 1'b1;
      end else if (r < -64'sd2147483648) begin
        r = -64'sd2147483648;
        m_sat = 1'b1;
      end
      m_yp[k] = r;
      m_xp[k] = x;
      yout[k*DW +: DW] = r[DW-1:0];
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the strobe for one cycle. If the DUT is expected to accept the
  // frame, push the model result.
  task automatic frame(input logic [1:0] m, input logic [CW-1:0] a,
                       input logic [NCH*DW-1:0] xin, input bit accept);
    exp_t e;
    logic [NCH*DW-1:0] y;
    @(negedge clk);
    mode     = m;
    alpha    = a;
    audio_in = xin;
    dlrck    = 1'b1;
    if (accept) begin
      model_frame(m, a, xin, y);
      e.data     = y;
      e.edge_cyc = cyc;
      e.sat      = m_sat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    dlrck = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_audio_out"}, audio_out, 64'h0);
    check({tag, "_flags"}, {60'h0, out_valid, busy, overrun, sat}, 64'h0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (overrun) ov_cnt++;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid actual=1 required=0 audio_out=0x%h (t=%0t)", audio_out, $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("audio_out", audio_out, mon_e.data);
          check("latency", 64'(cyc), 64'(mon_e.edge_cyc + 8));
          check("sat", {63'h0, sat}, {63'h0, mon_e.sat});
          $display("frame edge=%0d out=0x%h sat=%0b", mon_e.edge_cyc, audio_out, sat);
        end
      end
    end
  end

  logic [1:0]      r_mode;
  logic [CW-1:0]   r_alpha;
  logic [DW-1:0]   r_x0, r_x1;

  initial begin
    rst_n    = 1'b0;
    dlrck    = 1'b0;
    mode     = 2'b00;
    alpha    = '0;
    audio_in = '0;
    model_reset();
    wait_cycles(3);
    check_idle_zero("reset");
    rst_n = 1'b1;
    wait_cycles(2);

    // Bypass, with a check of busy width
    busy_cnt = 0;
    frame(2'b00, 16'h0, {32'hFFFFFF00, 32'h00001234}, 1'b1);
    wait_cycles(10);
    check("busy_cycles", 64'(busy_cnt), 64'd8);

    // High-pass, alpha 0.5, x held at 1000
    repeat (3) begin
      frame(2'b01, 16'h4000, {32'd1000, 32'd1000}, 1'b1);
      wait_cycles(10);
    end

    // Low-pass, alpha 0.25, x=-4000, then switch to high-pass
    repeat (2) begin
      frame(2'b10, 16'h2000, {-32'sd4000, -32'sd4000}, 1'b1);
      wait_cycles(10);
    end
    frame(2'b01, 16'h4000, {-32'sd4000, -32'sd4000}, 1'b1);
    wait_cycles(10);

    // Second strobe three cycles after the first
    ov_cnt = 0;
    frame(2'b01, 16'h4000, {32'd777, -32'sd555}, 1'b1);
    wait_cycles(1);
    frame(2'b01, 16'h4000, {32'h1111_1111, 32'h2222_2222}, 1'b0);
    wait_cycles(12);
    check("overrun_pulses", 64'(ov_cnt), 64'd1);

    // Reset in the middle of a frame
    frame(2'b10, 16'h6000, {32'd5000, 32'd6000}, 1'b1);
    wait_cycles(3);
    rst_n = 1'b0;
    sb_q.delete();
    model_reset();
    wait_cycles(1);
    check_idle_zero("midreset");
    rst_n = 1'b1;
    wait_cycles(3);
    check_idle_zero("after_reset");

    // Saturation from reset, then a non-clipping frame
    frame(2'b01, 16'h8001, {32'h7FFFFFFF, 32'h7FFFFFFF}, 1'b1);
    wait_cycles(10);
    frame(2'b11, 16'h1234, {32'd42, -32'sd42}, 1'b1);
    wait_cycles(10);
    check("sat_sticky", {63'h0, sat}, 64'h1);

    // Random frames. The mode is often held so that history carries over.
    r_mode = 2'b01;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) r_mode = 2'($urandom_range(0, 3));
      r_alpha = 16'($urandom());
      if ($urandom_range(0, 1) == 0) begin
        r_x0 = $urandom();
        r_x1 = $urandom();
      end else begin
        r_x0 = 32'($signed($urandom_range(0, 20000)) - 10000);
        r_x1 = 32'($signed($urandom_range(0, 20000)) - 10000);
      end
      frame(r_mode, r_alpha, {r_x1, r_x0}, 1'b1);
      wait_cycles(10);
    end

    wait_cycles(5);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
